// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, transfer direction constants and default
// bus geometry for the APB master, the apb_regs slaves and their benches.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam logic WRITE = 1'b1;
    localparam logic READ  = 1'b0;

    localparam int APB_AW = 5;
    localparam int APB_DW = 32;

endpackage

// File: rtl/apb_master_arb_if.sv
// apb_master_arb_if: the two requester command/response channels plus the
// shared APB bus. "master" is the view of apb_master_arb; "slave" is the view
// of whatever sits around it (requesters and APB slaves).
interface apb_master_arb_if #(
    parameter int DW = 32,
    parameter int NS = 2
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_write;
    logic [31:0]      req0_addr;
    logic [DW-1:0]    req0_wdata;
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_write;
    logic [31:0]      req1_addr;
    logic [DW-1:0]    req1_wdata;

    logic             rsp0_valid;
    logic [DW-1:0]    rsp0_rdata;
    logic             rsp0_err;
    logic             rsp1_valid;
    logic [DW-1:0]    rsp1_rdata;
    logic             rsp1_err;

    logic [31:0]      paddr;
    logic             pwrite;
    logic [DW-1:0]    pwdata;
    logic [NS-1:0]    psel;
    logic             penable;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]    pready;
    logic [NS-1:0]    pslverr;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp0_err,
        output rsp1_valid, rsp1_rdata, rsp1_err,
        output paddr, pwrite, pwdata, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp0_err,
        input  rsp1_valid, rsp1_rdata, rsp1_err,
        input  paddr, pwrite, pwdata, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_rr_arb.sv
// apb_rr_arb: 2-way round-robin arbiter. The grant is combinational from the
// requests; the pointer moves only when the owner actually takes a grant.
module apb_rr_arb (
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic favour_r1;

    // A lone requester always wins; on a tie the favoured requester wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = favour_r1 ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After a grant, favour the other requester; r0 is favoured out of reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            favour_r1 <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            favour_r1 <= gnt[0];
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester APB master. Arbitrates round-robin, runs the
// SETUP/ACCESS phases, decodes paddr[31:AW] into a one-hot psel and returns a
// registered one-cycle response to the requester that was granted.
// Optional build macro APB_MASTER_TIMEOUT_EN adds an ACCESS-phase watchdog
// that aborts with an error after TO_CYC consecutive not-ready cycles.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int AW     = APB_AW,
    parameter int DW     = APB_DW,
    parameter int NS     = 2,
    parameter int TO_CYC = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_master_arb_if.master bus
);

    localparam int            IW     = 32 - AW;
    localparam logic [IW-1:0] NS_IDX = IW'(NS);

    apb_state_t    state;
    logic          owner;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          accept;

    logic          c_write;
    logic [31:0]   c_addr;
    logic [DW-1:0] c_wdata;
    logic [IW-1:0] c_idx;
    logic          c_hit;

    logic          s_ready;
    logic          s_err;
    logic [DW-1:0] s_rdata;
    logic          to_fire;

    assign req = {bus.req1_valid, bus.req0_valid};

    apb_rr_arb u_arb (
        .pclk    (pclk),
        .presetn (presetn),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    // Ready is masked by reset so every output reads 0 while presetn is low.
    assign accept         = presetn && (state == IDLE) && (gnt != 2'b00);
    assign bus.req0_ready = accept && gnt[0];
    assign bus.req1_ready = accept && gnt[1];

    assign bus.rsp0_rdata = rsp_rdata;
    assign bus.rsp0_err   = rsp_err;
    assign bus.rsp1_rdata = rsp_rdata;
    assign bus.rsp1_err   = rsp_err;

    // Payload of whichever requester the arbiter is granting this cycle.
    always_comb begin
        c_write = bus.req0_write;
        c_addr  = bus.req0_addr;
        c_wdata = bus.req0_wdata;
        if (gnt[1]) begin
            c_write = bus.req1_write;
            c_addr  = bus.req1_addr;
            c_wdata = bus.req1_wdata;
        end
    end

    assign c_idx = c_addr[31:AW];
    assign c_hit = (c_idx < NS_IDX);

    // Slave-side mux keyed on the one-hot psel so no index decode is needed.
    always_comb begin
        s_ready = 1'b0;
        s_err   = 1'b0;
        s_rdata = '0;
        for (int k = 0; k < NS; k++) begin
            if (bus.psel[k]) begin
                s_ready = s_ready | bus.pready[k];
                s_err   = s_err | bus.pslverr[k];
                s_rdata = s_rdata | bus.prdata[k*DW +: DW];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);

    logic [TW-1:0] to_cnt;

    assign to_fire = (state == ACCESS) && !s_ready && (to_cnt == TW'(TO_CYC - 1));

    // Watchdog: counts consecutive not-ready ACCESS cycles, cleared in SETUP.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !s_ready) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`else
    // No watchdog: ACCESS waits on pready indefinitely. TO_CYC is a cycle
    // count and never negative, so this folds to a constant 0.
    assign to_fire = (TO_CYC < 0);
`endif

    // Main FSM: arbitration/decode in IDLE, APB phases, registered response.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state          <= IDLE;
            owner          <= 1'b0;
            bus.paddr      <= '0;
            bus.pwrite     <= 1'b0;
            bus.pwdata     <= '0;
            bus.psel       <= '0;
            bus.penable    <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
        end else begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= gnt[1];
                        if (c_hit) begin
                            bus.paddr  <= c_addr;
                            bus.pwrite <= c_write;
                            bus.pwdata <= c_wdata;
                            bus.psel   <= NS'(1) << c_idx;
                            state      <= SETUP;
                        end else begin
                            bus.rsp0_valid <= gnt[0];
                            bus.rsp1_valid <= gnt[1];
                            rsp_rdata      <= '0;
                            rsp_err        <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (s_ready || to_fire) begin
                        bus.psel       <= '0;
                        bus.penable    <= 1'b0;
                        bus.pwrite     <= 1'b0;
                        bus.rsp0_valid <= !owner;
                        bus.rsp1_valid <= owner;
                        rsp_err        <= s_ready ? s_err : 1'b1;
                        rsp_rdata      <= (s_ready && !s_err && (bus.pwrite == READ)) ? s_rdata : '0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed bench for apb_master_arb with two behavioural
// 8-word APB slaves (slave 0 has programmable wait states, error and stuck
// controls). Honours APB_MASTER_TIMEOUT_EN the same way as the design.
module tb_apb_master_arb;
    import apb_pkg::*;

    logic pclk = 1'b0;
    logic presetn = 1'b0;

    apb_master_arb_if #(.DW(32), .NS(2)) bus ();

    apb_master_arb #(.AW(5), .DW(32), .NS(2), .TO_CYC(16)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem [2][8];
    int          wait0   = 0;
    bit          stuck   = 1'b0;
    bit          err_inj = 1'b0;
    int          acc     = 0;

    assign bus.prdata  = {mem[1][bus.paddr[4:2]], mem[0][bus.paddr[4:2]]};
    assign bus.pready  = {1'b1, !stuck && (acc >= wait0)};
    assign bus.pslverr = {1'b0, err_inj};

    // Slave 0 wait-state counter: counts not-ready ACCESS cycles.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) acc <= 0;
        else if (bus.penable && !bus.pready[0]) acc <= acc + 1;
        else acc <= 0;
    end

    // Slave register write on a completing write ACCESS.
    always @(posedge pclk) begin
        for (int k = 0; k < 2; k++)
            if (bus.penable && bus.psel[k] && bus.pready[k] && bus.pwrite)
                mem[k][bus.paddr[4:2]] <= bus.pwdata;
    end

    logic [31:0] res_rdata;
    logic        res_err;
    int          res_lat;
    logic [1:0]  res_psel;
    int          res_pen;
    bit          res_unstable;
    bit          res_ok;
    logic        res_pwrite;
    logic [31:0] res_paddr;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    // One command from requester r; results land in the res_* variables.
    task automatic apply_stimulus(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int          t;
        bit          seen;
        logic [1:0]  psel_ref;
        logic [31:0] paddr_ref;
        res_ok = 1'b0; res_lat = 0; res_psel = 2'b00; res_pen = 0; res_unstable = 1'b0;
        res_rdata = 'x; res_err = 1'bx; seen = 1'b0; psel_ref = 2'b00; paddr_ref = '0;
        @(negedge pclk);
        drive(r, 1'b1, wr, a, d);
        #1;
        t = 0;
        while (!(r == 0 ? bus.req0_ready : bus.req1_ready) && t < 20) begin
            @(negedge pclk);
            t++;
        end
        if (t >= 20) begin
            drive(r, 1'b0, wr, a, d);
            return;
        end
        @(posedge pclk);
        #1;
        drive(r, 1'b0, wr, a, d);
        while (!res_ok && res_lat < 100) begin
            @(negedge pclk);
            res_lat++;
            res_psel |= bus.psel;
            if (bus.penable) res_pen++;
            if (bus.psel != 2'b00) begin
                if (seen && (bus.psel != psel_ref || bus.paddr != paddr_ref)) res_unstable = 1'b1;
                seen = 1'b1; psel_ref = bus.psel; paddr_ref = bus.paddr;
            end
            if (r == 0 ? bus.rsp0_valid : bus.rsp1_valid) begin
                res_ok     = 1'b1;
                res_rdata  = (r == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
                res_err    = (r == 0) ? bus.rsp0_err : bus.rsp1_err;
                res_pwrite = bus.pwrite;
                res_paddr  = bus.paddr;
            end
        end
    endtask

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed hang expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int   t;
        int   n_g;
        int   n_r;
        bit   dbl;
        int   rdy_cyc [4];
        int   rdy_who [4];
        int   rsp_cyc [4];
        int   rsp_who [4];
        logic any_out;

        drive(0, 1'b1, READ, 32'h0, 32'h0);
        drive(1, 1'b0, READ, 32'h0, 32'h0);

        // Reset state: outputs 0, ready masked even with a valid request.
        #12;
        any_out = (|bus.psel) | bus.penable | bus.pwrite | (|bus.paddr) | (|bus.pwdata) |
                  bus.rsp0_valid | bus.rsp1_valid | bus.rsp0_err | (|bus.rsp0_rdata);
        check_output("reset_outputs", any_out, 1'b0);
        check_output("reset_ready", bus.req0_ready, 1'b0);
        drive(0, 1'b0, READ, 32'h0, 32'h0);
        @(negedge pclk);
        presetn = 1'b1;

        // r0 writes slave 0 then slave 1.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, WRITE, 32'(i * 4), 32'hFFFF_FF00 + 32'(i));
            check_output("wr0_done", res_ok, 1'b1);
            check_output("wr0_psel", res_psel, 2'b01);
            check_output("wr0_err", res_err, 1'b0);
            check_output("wr0_lat", res_lat, 3);
        end
        check_output("idle_pwrite", res_pwrite, 1'b0);
        check_output("idle_paddr_hold", res_paddr, 32'h1C);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, WRITE, 32'h20 + 32'(i * 4), 32'hFFFF_FF80 + 32'(i));
            check_output("wr1_psel", res_psel, 2'b10);
            check_output("wr1_err", res_err, 1'b0);
        end

        // r0 reads slave 1 back.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, READ, 32'h20 + 32'(i * 4), 32'h0);
            check_output("rd1_data", res_rdata, 32'hFFFF_FF80 + 32'(i));
            check_output("rd1_psel", res_psel, 2'b10);
            check_output("rd1_err", res_err, 1'b0);
        end

        // Lone r1 read; also leaves r0 favoured for the contention run.
        apply_stimulus(1, READ, 32'h00, 32'h0);
        check_output("r1_data", res_rdata, 32'hFFFF_FF00);
        check_output("r1_lat", res_lat, 3);

        // Contention: both valid from the same cycle.
        n_g = 0; n_r = 0; dbl = 1'b0;
        @(negedge pclk);
        drive(0, 1'b1, READ, 32'h00, 32'h0);
        drive(1, 1'b1, READ, 32'h24, 32'h0);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) dbl = 1'b1;
            if (bus.req0_ready || bus.req1_ready) begin
                if (n_g < 4) begin rdy_cyc[n_g] = c; rdy_who[n_g] = int'(bus.req1_ready); end
                n_g++;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (n_r < 4) begin rsp_cyc[n_r] = c; rsp_who[n_r] = int'(bus.rsp1_valid); end
                n_r++;
            end
            @(posedge pclk);
            #1;
            if (n_g >= 4) begin
                drive(0, 1'b0, READ, 32'h00, 32'h0);
                drive(1, 1'b0, READ, 32'h24, 32'h0);
            end
            @(negedge pclk);
        end
        check_output("cont_double_ready", dbl, 1'b0);
        check_output("cont_grants", n_g, 4);
        check_output("cont_rsps", n_r, 4);
        for (int i = 0; i < 4; i++) begin
            if (n_g == 4 && n_r == 4) begin
                check_output("cont_who", rdy_who[i], i % 2);
                check_output("cont_ready_cyc", rdy_cyc[i], 3 * i);
                check_output("cont_rsp_cyc", rsp_cyc[i], 3 * i + 3);
                check_output("cont_rsp_who", rsp_who[i], i % 2);
            end
        end

        // Wait states on slave 0.
        wait0 = 3;
        apply_stimulus(0, READ, 32'h04, 32'h0);
        check_output("wait_lat", res_lat, 6);
        check_output("wait_penable_cyc", res_pen, 4);
        check_output("wait_stable", res_unstable, 1'b0);
        check_output("wait_data", res_rdata, 32'hFFFF_FF01);
        wait0 = 0;

        // Slave error.
        err_inj = 1'b1;
        apply_stimulus(0, READ, 32'h08, 32'h0);
        check_output("slverr_err", res_err, 1'b1);
        check_output("slverr_rdata", res_rdata, 32'h0);
        err_inj = 1'b0;

        // Decode miss.
        apply_stimulus(0, READ, 32'h40, 32'h0);
        check_output("miss_lat", res_lat, 1);
        check_output("miss_err", res_err, 1'b1);
        check_output("miss_rdata", res_rdata, 32'h0);
        check_output("miss_psel", res_psel, 2'b00);

        // Stuck slave: watchdog abort, or indefinite wait without it.
        stuck = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        apply_stimulus(0, READ, 32'h0C, 32'h0);
        check_output("to_lat", res_lat, 18);
        check_output("to_penable_cyc", res_pen, 16);
        check_output("to_err", res_err, 1'b1);
        check_output("to_rdata", res_rdata, 32'h0);
        @(negedge pclk);
        drive(0, 1'b1, READ, 32'h0C, 32'h0);
        #1;
        t = 0;
        while (!bus.req0_ready && t < 10) begin @(negedge pclk); t++; end
        check_output("stuck_accept", t < 10, 1'b1);
        @(posedge pclk);
        #1;
        drive(0, 1'b0, READ, 32'h0C, 32'h0);
        repeat (4) @(negedge pclk);
`else
        @(negedge pclk);
        drive(0, 1'b1, READ, 32'h0C, 32'h0);
        #1;
        t = 0;
        while (!bus.req0_ready && t < 10) begin @(negedge pclk); t++; end
        check_output("stuck_accept", t < 10, 1'b1);
        @(posedge pclk);
        #1;
        drive(0, 1'b0, READ, 32'h0C, 32'h0);
        repeat (100) @(negedge pclk);
        check_output("stuck_psel_100", bus.psel, 2'b01);
        check_output("stuck_rsp_100", bus.rsp0_valid, 1'b0);
`endif
        check_output("pre_reset_penable", bus.penable, 1'b1);

        // Mid-transfer reset: asynchronous clear, no response afterwards.
        #2;
        presetn = 1'b0;
        #1;
        any_out = (|bus.psel) | bus.penable | bus.pwrite | (|bus.paddr) | (|bus.pwdata) |
                  bus.rsp0_valid | bus.rsp1_valid | bus.rsp0_err | bus.rsp1_err |
                  (|bus.rsp0_rdata) | bus.req0_ready | bus.req1_ready;
        check_output("async_reset_outputs", any_out, 1'b0);
        stuck = 1'b0;
        repeat (2) @(negedge pclk);
        #2;
        presetn = 1'b1;
        n_r = 0;
        repeat (5) begin
            @(negedge pclk);
            if (bus.rsp0_valid || bus.rsp1_valid) n_r++;
        end
        check_output("reset_no_rsp", n_r, 0);

        // First tie after reset goes to r0.
        drive(0, 1'b1, READ, 32'h00, 32'h0);
        drive(1, 1'b1, READ, 32'h20, 32'h0);
        #1;
        check_output("post_reset_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(posedge pclk);
        #1;
        drive(0, 1'b0, READ, 32'h00, 32'h0);
        drive(1, 1'b0, READ, 32'h20, 32'h0);
        t = 0;
        while (!bus.rsp0_valid && t < 10) begin @(negedge pclk); t++; end
        check_output("post_reset_rsp", t < 10, 1'b1);
        check_output("post_reset_data", bus.rsp0_rdata, 32'hFFFF_FF00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master that shares one APB bus among several `apb_regs` slaves. It accepts simple valid/ready commands from two requesters and arbitrates between them round-robin. It drives the APB SETUP and ACCESS phases, decodes `paddr[31:AW]` into one `psel` per slave, waits on `pready`, and returns read data and error status to the winning requester. It replaces hand-sequenced APB traffic at the top of the register subsystem.

## Interface
- `AW`, default 5: per-slave address window width; slave index = `addr[31:AW]`.
- `DW`, default 32: data width.
- `NS`, default 2: number of slaves.
- `TO_CYC`, default 16: ACCESS-phase wait limit; used only with the timeout feature.

Ports:
- `pclk`  in  1  clock.
- `presetn`  in  1  reset, asynchronous, active-low.
- `reqN_valid`  in  1  command valid, N = 0, 1. Must stay high with a stable payload until `reqN_ready`.
- `reqN_ready`  out  1  command accepted this cycle.
- `reqN_write`  in  1  1 = WRITE, 0 = READ.
- `reqN_addr`  in  32  byte address.
- `reqN_wdata`  in  DW  write data.
- `rspN_valid`  out  1  one-cycle completion pulse. There is no backpressure.
- `rspN_rdata`  out  DW  read data. 0 for writes and errors.
- `rspN_err`  out  1  slave error, decode miss, or timeout.
- `paddr`  out  32  APB address.
- `pwrite`  out  1  APB direction.
- `pwdata`  out  DW  APB write data.
- `psel`  out  NS  one-hot slave select.
- `penable`  out  1  ACCESS phase.
- `prdata`  in  NS*DW  slave read data, flattened; slave k occupies bits [k*DW +: DW].
- `pready`  in  NS  per-slave ready.
- `pslverr`  in  NS  per-slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **Arbitration in IDLE:**
  - If any `reqN_valid` is high, the arbiter grants one requester and pulses its `reqN_ready`.
  - The arbiter latches addr, write and wdata, then moves to SETUP.
  - When both requesters are valid, the one not granted last wins. The pointer favours r0 after reset.
  - A lone requester always wins.
- **Address decode:**
  - idx = `addr[31:AW]`.
  - If idx >= NS (miss), no APB cycle occurs. The next cycle gives `rsp_valid` = 1, `err` = 1, `rdata` = 0, and the FSM stays in IDLE.
- **SETUP:** `psel[idx]` = 1, `penable` = 0, `paddr`/`pwrite`/`pwdata` driven from the latched command. Next state is ACCESS.
- **ACCESS:** `penable` = 1, with psel and address/data held.
  - On a cycle with `pready[idx]` = 1, the transfer completes.
  - On completion, `prdata[idx]` is captured (reads only) along with `pslverr[idx]`.
  - On completion, `psel` and `penable` drop, and the FSM returns to IDLE.
- **Response:** `rspN_valid` is registered, so it is high in the cycle after completion, only for the granted requester.
- **Bus fields when idle:** `paddr`, `pwrite` and `pwdata` hold their last value when idle; `pwrite` returns to 0.
- **Reset values:** all outputs are 0, state is IDLE, and the arbitration pointer is r0.
- **Reset during a transfer:** reset aborts the transfer immediately. No response is produced for the aborted command.

## Timing
- Command accepted at edge T. SETUP occupies cycle T+1 and ACCESS begins at T+2.
- A zero-wait slave completes at edge T+3. `rsp_valid` is high in cycle T+3, and that same cycle is IDLE, so it can accept the next command.
- Throughput: one transfer per 3 cycles with zero-wait slaves.
- Each `pready` = 0 cycle adds one cycle of latency.
- Decode miss: accepted at T, response in cycle T+1.
- `reqN_ready` is only ever high in IDLE and never high for both requesters in the same cycle.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entering ACCESS.
  - If `pready` stays low for `TO_CYC` consecutive ACCESS cycles, the FSM drops `psel`/`penable`, returns to IDLE, and responds with `err` = 1, `rdata` = 0.
- `APB_MASTER_TIMEOUT_EN` undefined: no counter is built, and ACCESS waits indefinitely for `pready`.

## Structure
- `apb_pkg` holds:
  - the state enum (IDLE/SETUP/ACCESS);
  - the `WRITE`=1/`READ`=0 constants;
  - the default `AW`/`DW` localparams shared with `apb_regs` and benches.
- Sub-module `apb_rr_arb`: 2-way round-robin arbiter. Inputs are req[1:0] and an advance strobe; the output is a one-hot grant.
- The FSM, decode, response registers and optional timeout counter live in `apb_master_arb`.

## Test plan
- **Writes then reads, r0 only:** r0 writes `0xFFFFFF00+i` to `0x00..0x1C`, then r0 reads `0x20..0x3C`.
  - Each write shows `psel` = `2'b01` and `rsp_err` = 0.
  - The slave 1 reads return the slave-1 write pattern `0xFFFFFF80+i`, with `psel` = `2'b10`.
- **Contention:** r0 and r1 both hold valid from the same cycle.
  - Grants alternate r0, r1, r0, … with no double ready.
  - Each `rsp_valid` arrives 3 cycles after the matching ready.
- **Wait states:** slave 0 holds `pready` low 3 cycles.
  - `penable` is high for 4 cycles and psel/paddr are stable throughout.
  - The response arrives at T+6.
- **Errors:** slave asserts `pslverr` → `rsp_err` = 1. Address `0x40` with NS = 2 → no `psel`, response at T+1 with `err` = 1 and `rdata` = 0.
- **Timeout (macro on, TO_CYC = 16):** `pready` is stuck low → `psel` drops after 16 ACCESS cycles and `err` = 1. With the macro off, the bus still waits at cycle 100.
- **Mid-transfer reset:** `presetn` low during ACCESS → all outputs 0 asynchronously and no `rsp_valid`. The first request after release is granted to r0.
